// File: rtl/common.sv
// Data-bus transaction types and the pipeline-size to bus-size mapping.
package common;

    localparam int DBUS_ADDR_W = 64;
    localparam int DBUS_DATA_W = 64;
    localparam int DBUS_STRB_W = DBUS_DATA_W / 8;

    // Bus size field carries log2 of the byte count.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic                   valid;
        logic [DBUS_ADDR_W-1:0] addr;
        msize_t                 size;
        logic [DBUS_STRB_W-1:0] strobe;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_resp_t;

    function automatic msize_t to_msize(input pipes::mem_size_t sz);
        msize_t m;
        case (sz)
            pipes::SIZE_B: m = MSIZE1;
            pipes::SIZE_H: m = MSIZE2;
            pipes::SIZE_W: m = MSIZE4;
            pipes::SIZE_D: m = MSIZE8;
            default:       m = MSIZE1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pipes.sv
// Pipeline-wide operation encodings shared between execute and memory stages.
package pipes;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    // Access size in bytes is 1 << encoding.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_t;

endpackage

// File: rtl/mem_align.sv
// Lane alignment helpers: misalign check, store strobe/shift, load extract/extend.
// Purely combinational; store side and load side have independent inputs.
module mem_align
    import pipes::*;
#(
    parameter int DATA_W = 64
) (
    input  mem_size_t                     st_size,
    input  logic                          st_store,
    input  logic [$clog2(DATA_W/8)-1:0]   st_off,
    input  logic [DATA_W-1:0]             st_wdata,
    output logic                          st_misalign,
    output logic [DATA_W/8-1:0]           st_strobe,
    output logic [DATA_W-1:0]             st_wdata_sh,
    input  mem_size_t                     ld_size,
    input  logic                          ld_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   ld_off,
    input  logic [DATA_W-1:0]             ld_rdata,
    output logic [DATA_W-1:0]             ld_rdata_ext
);

    localparam int STRB_W = DATA_W / 8;

    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] ld_shifted;

    // Misalign check and lane strobe/data placement for the outgoing access.
    always_comb begin
        st_misalign = 1'b0;
        strb_base   = '0;
        case (st_size)
            SIZE_B: begin
                st_misalign = 1'b0;
                strb_base   = STRB_W'(1);
            end
            SIZE_H: begin
                st_misalign = st_off[0];
                strb_base   = STRB_W'(3);
            end
            SIZE_W: begin
                st_misalign = |st_off[1:0];
                strb_base   = STRB_W'(4'hF);
            end
            SIZE_D: begin
                // A doubleword cannot fit on a 32-bit bus at all.
                st_misalign = (DATA_W == 32) ? 1'b1 : |st_off;
                strb_base   = '1;
            end
            default: begin
                st_misalign = 1'b1;
                strb_base   = '0;
            end
        endcase
        st_strobe   = st_store ? (strb_base << st_off) : '0;
        st_wdata_sh = st_wdata << {st_off, 3'b000};
    end

    // Right-justify returned bus data and extend to full register width.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SIZE_B: begin
                if (ld_unsigned) ld_rdata_ext = DATA_W'(ld_shifted[7:0]);
                else             ld_rdata_ext = DATA_W'($signed(ld_shifted[7:0]));
            end
            SIZE_H: begin
                if (ld_unsigned) ld_rdata_ext = DATA_W'(ld_shifted[15:0]);
                else             ld_rdata_ext = DATA_W'($signed(ld_shifted[15:0]));
            end
            SIZE_W: begin
                if (ld_unsigned) ld_rdata_ext = DATA_W'(ld_shifted[31:0]);
                else             ld_rdata_ext = DATA_W'($signed(ld_shifted[31:0]));
            end
            default: ld_rdata_ext = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access unit: turns load/store requests into dbus transactions.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access outstanding; accepts aligned requests, flags misaligned
// REQ     | dreq.valid high, waiting for addr_ok (or data_ok directly)
// RESP    | address accepted, dreq.valid low, waiting for data_ok
module mem_access
    import pipes::*;
    import common::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  mem_op_t           in_op,
    input  mem_size_t         in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_misalign,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_size_t         size_q, size_d;
    logic [STRB_W-1:0] strobe_q, strobe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              uns_q, uns_d;
    logic              load_q, load_d;
    logic              out_valid_q, out_valid_d;
    logic              out_misalign_q, out_misalign_d;
    logic [DATA_W-1:0] out_rdata_q, out_rdata_d;

    logic              accept;
    logic              done;
    logic              al_misalign;
    logic [STRB_W-1:0] al_strobe;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata_ext;

    // Store side sees the live request; load side sees the registered request.
    mem_align #(.DATA_W(DATA_W)) u_align (
        .st_size      (in_size),
        .st_store     (in_op == MEM_STORE),
        .st_off       (in_addr[OFF_W-1:0]),
        .st_wdata     (in_wdata),
        .st_misalign  (al_misalign),
        .st_strobe    (al_strobe),
        .st_wdata_sh  (al_wdata),
        .ld_size      (size_q),
        .ld_unsigned  (uns_q),
        .ld_off       (off_q),
        .ld_rdata     (DATA_W'(dresp.data)),
        .ld_rdata_ext (al_rdata_ext)
    );

    assign accept = (state_q == ST_IDLE) && in_valid && (in_op != MEM_NONE);
    assign done   = (state_q != ST_IDLE) && dresp.data_ok;

    // Next-state, request capture and completion result.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        strobe_d       = strobe_q;
        wdata_d        = wdata_q;
        off_d          = off_q;
        uns_d          = uns_q;
        load_d         = load_q;
        out_valid_d    = 1'b0;
        out_misalign_d = 1'b0;
        out_rdata_d    = out_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (al_misalign) begin
                        out_valid_d    = 1'b1;
                        out_misalign_d = 1'b1;
                        out_rdata_d    = '0;
                    end else begin
                        addr_d   = in_addr;
                        size_d   = in_size;
                        strobe_d = al_strobe;
                        wdata_d  = al_wdata;
                        off_d    = in_addr[OFF_W-1:0];
                        uns_d    = in_unsigned;
                        load_d   = (in_op == MEM_LOAD);
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (!dresp.data_ok && dresp.addr_ok) state_d = ST_RESP;
            end
            ST_RESP: ;
            default: state_d = ST_IDLE;
        endcase
        if (done) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            out_rdata_d = load_q ? al_rdata_ext : '0;
        end
    end

    // State and request registers; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            size_q         <= SIZE_B;
            strobe_q       <= '0;
            wdata_q        <= '0;
            off_q          <= '0;
            uns_q          <= 1'b0;
            load_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_misalign_q <= 1'b0;
            out_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            strobe_q       <= strobe_d;
            wdata_q        <= wdata_d;
            off_q          <= off_d;
            uns_q          <= uns_d;
            load_q         <= load_d;
            out_valid_q    <= out_valid_d;
            out_misalign_q <= out_misalign_d;
            out_rdata_q    <= out_rdata_d;
        end
    end

    // Bus request driven straight from registers so it is stable until data_ok.
    always_comb begin
        dreq        = '0;
        dreq.valid  = (state_q == ST_REQ);
        dreq.addr   = DBUS_ADDR_W'(addr_q);
        dreq.size   = to_msize(size_q);
        dreq.strobe = DBUS_STRB_W'(strobe_q);
        dreq.data   = DBUS_DATA_W'(wdata_q);
    end

    // Stall is combinational so upstream freezes in the accept cycle itself.
    assign busy         = (accept && !al_misalign) || (state_q != ST_IDLE);
    assign out_valid    = out_valid_q;
    assign out_misalign = out_misalign_q;
    assign out_rdata    = out_rdata_q;

endmodule
